mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between instruction fetch (IF) and the load/store unit (LS) of the RISC-V core.
- Grants at most one access per cycle.
- Routes read data back to the owner one cycle later.
- Raises a core stall whenever a requester is refused.
- Sits between the core and the unified instruction/data memory in the top level.

Parameters:
ADDR_W, 32, address width in bits (byte address).
DATA_W, 32, data word width in bits.
MAX_LS_STREAK, 4, max consecutive LS grants while IF is waiting before IF is forced through (range 1..15).

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  IF read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  IF fetch address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  DATA_W  fetched instruction word
ls_req  in  1  LS request; held with all ls_* stable until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_be  in  DATA_W/8  byte enables for stores
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  ls_rdata valid (cycle after a load grant)
ls_rdata  out  DATA_W  load data
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & ~mem_we
stall  out  1  (if_req & ~if_gnt) | (ls_req & ~ls_gnt)

Behaviour:
- Reset (rst=1 at clk edge): state=S_IDLE, streak=0.
  - While rst=1, all grants, mem_en, mem_we, rvalids and stall are forced 0.
  - All data outputs are 0.
- Grant is combinational in the request cycle.
  - Only LS requesting -> LS.
  - Only IF requesting -> IF.
  - Both requesting -> LS, unless streak == MAX_LS_STREAK, in which case IF.
- Memory mux is combinational from the winner; mem_en = if_gnt | ls_gnt.
  - IF grant: mem_we=0, mem_be=all ones.
  - LS grant: ls_we, ls_be, ls_wdata are passed through.
  - No grant: mem_en=0, mem_we=0, addr/wdata/be=0.
- Streak counter (registered):
  - LS grant while if_req=1: increment, saturating at MAX_LS_STREAK.
  - Any IF grant: clear to 0.
  - if_req=0: clear to 0.
- FSM records the last-cycle issue: S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR. Next state = type of the grant issued this cycle, or S_IDLE if none.
- Read return, latency exactly 1 cycle:
  - S_IF_RD -> if_rvalid=1, if_rdata=mem_rdata.
  - S_LS_RD -> ls_rvalid=1, ls_rdata=mem_rdata.
  - S_LS_WR and S_IDLE -> no rvalid.
  - Data outputs are 0 when the matching rvalid is 0.
- Back-to-back: a new grant may be issued in the same cycle as the previous read's rvalid (full throughput, one access/cycle).
- Request dropped before grant: allowed, no side effects. Signals changing while req is held: undefined, checked by assertion in the bench.
- Reset mid-operation: the pending rvalid of a granted read is discarded (state -> S_IDLE).

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR};
  - typedef enum logic arb_owner_t {OWN_IF, OWN_LS};
  - localparam STREAK_W = 4.
- One natural sub-module, arb_priority_sel: combinational winner select from if_req, ls_req and the streak-saturated flag.

Test Plan:
1. IF-only reads at 0x00, 0x04, 0x08 on consecutive cycles, mem preloaded 0x00500113/0x00C00193/0x002081B3 -> if_gnt=1 each cycle; if_rvalid one cycle later with those words in order; stall=0.
2. Both requesting, LS load 0x100 (mem=0xDEADBEEF), IF at 0x0C -> ls_gnt=1, if_gnt=0, stall=1; next cycle ls_rvalid=1, ls_rdata=0xDEADBEEF, if_gnt=1.
3. LS store ls_be=4'b0011, wdata=0x0000ABCD to 0x200 -> mem_en=1, mem_we=1, mem_be=0011; no ls_rvalid next cycle; a subsequent load of 0x200 returns the low half 0xABCD.
4. Continuous LS loads with IF held requesting, MAX_LS_STREAK=4 -> ls_gnt on 4 cycles, then if_gnt on the 5th, then LS resumes; streak returns to 0 after the IF grant.
5. IF read granted, rst=1 the next cycle, then rst=0 -> no if_rvalid ever appears for that read; all outputs 0 during reset; the first post-reset IF request is granted normally.
6. Reset held 2 cycles, then released with no requests -> mem_en=0, stall=0, state S_IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
//   arb_state_t : the kind of access issued in the previous cycle; it decides
//                 which read-data return path is active in the current cycle
//   arb_owner_t : winner reported by the priority selector
//   STREAK_W    : width of the consecutive-LS-grant counter (MAX_LS_STREAK <= 15)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IF_RD = 2'd1,
        S_LS_RD = 2'd2,
        S_LS_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner selection between instruction fetch and load/store.
// Ports:
//   if_req_i     - IF is requesting
//   ls_req_i     - LS is requesting
//   streak_sat_i - LS has won MAX_LS_STREAK times in a row while IF waited
//   any_o        - at least one requester wins this cycle
//   owner_o      - which requester wins (only meaningful when any_o = 1)
// LS normally has priority; once the streak saturates a waiting IF wins so
// instruction fetch cannot be starved by a long run of loads/stores.
module arb_priority_sel
    import mem_arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  logic       streak_sat_i,
    output logic       any_o,
    output arb_owner_t owner_o
);

    assign any_o   = if_req_i | ls_req_i;
    assign owner_o = (ls_req_i && !(if_req_i && streak_sat_i)) ? OWN_LS : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF)
// and the load/store unit (LS). At most one access is issued per cycle.
//
// Handshake: a requester raises *_req and holds it with its address/data
// stable until it sees *_gnt high in the same cycle; the grant is
// combinational, so a request granted in cycle N is gone from the arbiter's
// view in cycle N+1. For reads, *_rvalid is high for exactly one cycle, the
// cycle after the grant, carrying mem_rdata. There is no back-pressure on the
// return path. A request may be withdrawn before it is granted.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   if_req/if_addr/if_gnt          - IF read request channel
//   if_rvalid/if_rdata             - IF read return
//   ls_req/ls_we/ls_be/ls_addr/
//   ls_wdata/ls_gnt                - LS request channel (load or store)
//   ls_rvalid/ls_rdata             - LS load return
//   mem_en/mem_we/mem_be/mem_addr/
//   mem_wdata/mem_rdata            - single-port memory interface
//   stall                          - some requester was refused this cycle
//   dbg_state_o, dbg_streak_o      - FSM state and streak counter for observation
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [DATA_W/8-1:0]   ls_be,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output arb_state_t            dbg_state_o,
    output logic [STREAK_W-1:0]   dbg_streak_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    arb_state_t            state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  streak_sat;
    logic                  any_win;
    arb_owner_t            owner;

    assign streak_sat = (streak_q == STREAK_MAX);

    arb_priority_sel u_sel (
        .if_req_i     (if_req),
        .ls_req_i     (ls_req),
        .streak_sat_i (streak_sat),
        .any_o        (any_win),
        .owner_o      (owner)
    );

    // Reset masks every grant so nothing reaches the memory while in reset.
    assign if_gnt = ~rst & any_win & (owner == OWN_IF);
    assign ls_gnt = ~rst & any_win & (owner == OWN_LS);
    assign stall  = ~rst & ((if_req & ~if_gnt) | (ls_req & ~ls_gnt));

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    // State records what was issued this cycle so the return path knows
    // who owns mem_rdata next cycle.
    always_comb begin
        state_d = S_IDLE;
        if (if_gnt) begin
            state_d = S_IF_RD;
        end else if (ls_gnt) begin
            state_d = ls_we ? S_LS_WR : S_LS_RD;
        end
    end

    // Counts LS wins that kept a requesting IF waiting; any IF win or IF
    // going quiet restarts the count.
    always_comb begin
        streak_d = streak_q;
        if (ls_gnt && if_req) begin
            streak_d = streak_sat ? streak_q : streak_q + STREAK_W'(1);
        end else if (if_gnt || !if_req) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign if_rvalid = ~rst & (state_q == S_IF_RD);
    assign ls_rvalid = ~rst & (state_q == S_LS_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    assign dbg_state_o  = state_q;
    assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural single-port memory answers the
// DUT's memory port, read words expected by each scenario are queued when the
// request is granted and checked when the matching rvalid appears.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    arb_state_t  dbg_state;
    logic [3:0]  dbg_streak;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_ls_q[$];
    logic [31:0] mem [0:255];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .dbg_state_o(dbg_state), .dbg_streak_o(dbg_streak)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata = mem[mem_addr[9:2]];
            end
        end
    end

    // ---------------- request stability assertion ----------------
    logic        p_if_pend, p_ls_pend;
    logic [31:0] p_if_addr;
    logic [69:0] p_ls_bus;
    initial begin
        p_if_pend = 1'b0;
        p_ls_pend = 1'b0;
    end
    always @(posedge clk) begin
        if (p_if_pend && if_req) assert (if_addr === p_if_addr) else $error("if_addr changed while held");
        if (p_ls_pend && ls_req) assert ({ls_we, ls_be, ls_addr, ls_wdata} === p_ls_bus) else $error("ls_* changed while held");
        p_if_pend <= if_req & ~if_gnt & ~rst;
        p_ls_pend <= ls_req & ~ls_gnt & ~rst;
        p_if_addr <= if_addr;
        p_ls_bus  <= {ls_we, ls_be, ls_addr, ls_wdata};
    end

    // ---------------- scoreboard ----------------
    logic [31:0] e_if, e_ls;
    always @(negedge clk) begin
        total++;
        if (if_rvalid) begin
            if (exp_if_q.size() == 0) begin
                bad++; $display("FAIL if_rvalid_unexpected got=%h exp=none", if_rdata);
            end else begin
                e_if = exp_if_q.pop_front();
                if (if_rdata !== e_if) begin bad++; $display("FAIL if_rdata got=%h exp=%h", if_rdata, e_if); end
            end
        end else if (if_rdata !== 32'h0) begin
            bad++; $display("FAIL if_rdata_idle got=%h exp=0", if_rdata);
        end
        total++;
        if (ls_rvalid) begin
            if (exp_ls_q.size() == 0) begin
                bad++; $display("FAIL ls_rvalid_unexpected got=%h exp=none", ls_rdata);
            end else begin
                e_ls = exp_ls_q.pop_front();
                if (ls_rdata !== e_ls) begin bad++; $display("FAIL ls_rdata got=%h exp=%h", ls_rdata, e_ls); end
            end
        end else if (ls_rdata !== 32'h0) begin
            bad++; $display("FAIL ls_rdata_idle got=%h exp=0", ls_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        cyc(); cyc();
        @(negedge clk);
        total++;
        if ({if_gnt, ls_gnt, mem_en, mem_we, if_rvalid, ls_rvalid, stall} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {if_gnt, ls_gnt, mem_en, mem_we, if_rvalid, ls_rvalid, stall});
        end
        total++;
        if (dbg_state !== S_IDLE || dbg_streak !== 4'd0) begin
            bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_streak);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_en !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_release got=%b%b exp=00", mem_en, stall);
        end
        cyc();
    endtask

    task automatic test_if_stream();
        logic [31:0] words [3];
        words[0] = 32'h00500113; words[1] = 32'h00C00193; words[2] = 32'h002081B3;
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = 32'(k * 4);
            @(negedge clk);
            total++;
            if ({if_gnt, ls_gnt, stall, mem_en, mem_we} !== 5'b10010 || mem_be !== 4'hF || mem_addr !== 32'(k * 4)) begin
                bad++; $display("FAIL if_stream_issue[%0d] got=%b be=%h a=%h exp=10010 be=f a=%h", k,
                                {if_gnt, ls_gnt, stall, mem_en, mem_we}, mem_be, mem_addr, k * 4);
            end
            total++;
            if (if_rvalid !== (k != 0)) begin
                bad++; $display("FAIL if_stream_rvalid[%0d] got=%b exp=%b", k, if_rvalid, k != 0);
            end
            exp_if_q.push_back(words[k]);
            cyc();
        end
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b1 || if_gnt !== 1'b0) begin
            bad++; $display("FAIL if_stream_tail got=%b%b exp=10", if_rvalid, if_gnt);
        end
        cyc();
    endtask

    task automatic test_both_req();
        if_req = 1'b1; if_addr = 32'h0C;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h100;
        @(negedge clk);
        total++;
        if ({ls_gnt, if_gnt, stall} !== 3'b101 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            bad++; $display("FAIL both_first got=%b a=%h exp=101 a=100", {ls_gnt, if_gnt, stall}, mem_addr);
        end
        exp_ls_q.push_back(32'hDEADBEEF);
        cyc();
        ls_req = 1'b0;
        @(negedge clk);
        total++;
        if ({ls_rvalid, if_gnt, stall} !== 3'b110 || mem_addr !== 32'h0C) begin
            bad++; $display("FAIL both_second got=%b a=%h exp=110 a=c", {ls_rvalid, if_gnt, stall}, mem_addr);
        end
        exp_if_q.push_back(32'h00000013);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if ({if_rvalid, ls_rvalid} !== 2'b10) begin
            bad++; $display("FAIL both_third got=%b exp=10", {if_rvalid, ls_rvalid});
        end
        cyc();
    endtask

    task automatic test_store_load();
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'h0000ABCD;
        @(negedge clk);
        total++;
        if ({ls_gnt, mem_en, mem_we, stall} !== 4'b1110 || mem_be !== 4'b0011 ||
            mem_addr !== 32'h200 || mem_wdata !== 32'h0000ABCD) begin
            bad++; $display("FAIL store_issue got=%b be=%b a=%h d=%h exp=1110 be=0011 a=200 d=0000abcd",
                            {ls_gnt, mem_en, mem_we, stall}, mem_be, mem_addr, mem_wdata);
        end
        cyc();
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0;
        @(negedge clk);
        total++;
        if (ls_rvalid !== 1'b0 || dbg_state !== S_LS_WR) begin
            bad++; $display("FAIL store_no_rvalid got=%b st=%0d exp=0 st=3", ls_rvalid, dbg_state);
        end
        cyc();
        ls_req = 1'b1; ls_be = 4'hF; ls_addr = 32'h200;
        @(negedge clk);
        total++;
        if ({ls_gnt, mem_we} !== 2'b10 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL load_issue got=%b d=%h exp=10 d=0", {ls_gnt, mem_we}, mem_wdata);
        end
        exp_ls_q.push_back(32'h1234ABCD);
        cyc();
        ls_req = 1'b0;
        @(negedge clk);
        total++;
        if (ls_rvalid !== 1'b1) begin bad++; $display("FAIL load_rvalid got=%b exp=1", ls_rvalid); end
        cyc();
    endtask

    task automatic test_ls_streak();
        int j;
        if_req = 1'b1; if_addr = 32'h0C;
        ls_we = 1'b0; ls_be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            j = (k < 4) ? k : 4;
            ls_req = 1'b1; ls_addr = 32'h300 + 32'(4 * j);
            if (k == 5) if_req = 1'b0;
            @(negedge clk);
            total++;
            if (ls_gnt !== (k != 4) || if_gnt !== (k == 4) || stall !== (k < 5)) begin
                bad++; $display("FAIL streak_gnt[%0d] got=%b%b%b exp=%b%b%b", k, ls_gnt, if_gnt, stall,
                                k != 4, k == 4, k < 5);
            end
            total++;
            if (dbg_streak !== ((k < 5) ? 4'(k) : 4'd0)) begin
                bad++; $display("FAIL streak_count[%0d] got=%0d exp=%0d", k, dbg_streak, (k < 5) ? k : 0);
            end
            if (k == 4) exp_if_q.push_back(32'h00000013);
            else        exp_ls_q.push_back(32'hA0000000 + 32'(j));
            cyc();
        end
        drive_idle();
        @(negedge clk);
        total++;
        if (dbg_streak !== 4'd0 || ls_rvalid !== 1'b1) begin
            bad++; $display("FAIL streak_end got=%0d/%b exp=0/1", dbg_streak, ls_rvalid);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h04;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt got=%b exp=1", if_gnt); end
        cyc();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h08;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h20; ls_wdata = 32'hFFFF0000;
        @(negedge clk);
        total++;
        if ({if_gnt, ls_gnt, mem_en, mem_we, if_rvalid, ls_rvalid, stall} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || if_rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%b a=%h d=%h be=%h r=%h exp=0", {if_gnt, ls_gnt, mem_en,
                            mem_we, if_rvalid, ls_rvalid, stall}, mem_addr, mem_wdata, mem_be, if_rdata);
        end
        cyc();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        total++;
        if ({if_rvalid, ls_rvalid} !== 2'b00 || dbg_state !== S_IDLE) begin
            bad++; $display("FAIL rstmid_discard got=%b st=%0d exp=00 st=0", {if_rvalid, ls_rvalid}, dbg_state);
        end
        cyc();
        if_req = 1'b1; if_addr = 32'h08;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1 || stall !== 1'b0) begin
            bad++; $display("FAIL rstmid_regrant got=%b%b exp=10", if_gnt, stall);
        end
        exp_if_q.push_back(32'h002081B3);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b1) begin bad++; $display("FAIL rstmid_rvalid got=%b exp=1", if_rvalid); end
        cyc();
    endtask

    task automatic test_reset_idle();
        rst = 1'b1;
        drive_idle();
        cyc(); cyc();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (mem_en !== 1'b0 || stall !== 1'b0 || dbg_state !== S_IDLE || dbg_streak !== 4'd0) begin
                bad++; $display("FAIL idle_after_reset[%0d] got=%b%b st=%0d sk=%0d exp=00 st=0 sk=0",
                                k, mem_en, stall, dbg_state, dbg_streak);
            end
            cyc();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00500113;
        mem[1]  = 32'h00C00193;
        mem[2]  = 32'h002081B3;
        mem[3]  = 32'h00000013;
        mem[64] = 32'hDEADBEEF;
        mem[128] = 32'h12345678;
        for (int i = 0; i < 5; i++) mem[192 + i] = 32'hA0000000 + 32'(i);
        mem_rdata = 32'h0;
        rst = 1'b1;
        drive_idle();

        test_reset();
        test_if_stream();
        test_both_req();
        test_store_load();
        test_ls_streak();
        test_reset_mid();
        test_reset_idle();

        total++;
        if (exp_if_q.size() != 0 || exp_ls_q.size() != 0) begin
            bad++; $display("FAIL queues_drained got=%0d/%0d exp=0/0", exp_if_q.size(), exp_ls_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
